// File: rtl/mc_pkg.sv
// mc_pkg: opcode/func constants, ALU and mux encodings, and the FSM state type for multicycle_ctrl.
package mc_pkg;
  localparam logic [5:0] OP_R0   = 6'b000000;
  localparam logic [5:0] OP_R1   = 6'b000001;
  localparam logic [5:0] OP_SH   = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000101;
  localparam logic [5:0] OP_ANDI = 6'b001001;
  localparam logic [5:0] OP_ORI  = 6'b001010;
  localparam logic [5:0] OP_XORI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b001101;
  localparam logic [5:0] OP_SW   = 6'b001110;
  localparam logic [5:0] OP_BEQ  = 6'b001111;
  localparam logic [5:0] OP_BNE  = 6'b010000;
  localparam logic [5:0] OP_J    = 6'b010010;
  localparam logic [2:0] FN_ADD = 3'b001;
  localparam logic [2:0] FN_AND = 3'b001;
  localparam logic [2:0] FN_OR  = 3'b010;
  localparam logic [2:0] FN_XOR = 3'b100;
  localparam logic [2:0] FN_SRA = 3'b001;
  localparam logic [2:0] FN_SRL = 3'b010;
  localparam logic [2:0] FN_SLL = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;
  localparam logic [1:0] ALUA_A     = 2'b00;
  localparam logic [1:0] ALUA_PC    = 2'b01;
  localparam logic [1:0] ALUA_SHAMT = 2'b10;
  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMM2  = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps op/func to a one-hot instruction class plus the EXE-stage ALU code and sign-extend need.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       rtype,
  output logic       shift,
  output logic       iarith,
  output logic       lw,
  output logic       sw,
  output logic       br,
  output logic       j,
  output logic       ill,
  output logic       bne,
  output logic       sext,
  output logic [2:0] aluc
);
  logic [2:0] f;
  logic       unused_func_hi;
  assign f = func[2:0];
  assign unused_func_hi = ^func[5:3];
  assign rtype  = (op == OP_R0 && f == FN_ADD) ||
                  (op == OP_R1 && (f == FN_AND || f == FN_OR || f == FN_XOR));
  assign shift  = op == OP_SH && (f == FN_SRA || f == FN_SRL || f == FN_SLL);
  assign iarith = op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_XORI;
  assign lw     = op == OP_LW;
  assign sw     = op == OP_SW;
  assign br     = op == OP_BEQ || op == OP_BNE;
  assign j      = op == OP_J;
  assign ill    = ~(rtype | shift | iarith | lw | sw | br | j);
  assign bne    = op == OP_BNE;
  assign sext   = op == OP_ADDI;
  // loads, stores and addi fall through to add
  assign aluc = op == OP_R1   ? (f == FN_AND ? ALU_AND : f == FN_OR ? ALU_OR : ALU_XOR) :
                op == OP_SH   ? (f == FN_SRA ? ALU_SRA : f == FN_SRL ? ALU_SRL : ALU_SLL) :
                op == OP_ANDI ? ALU_AND :
                op == OP_ORI  ? ALU_OR  :
                op == OP_XORI ? ALU_XOR : ALU_ADD;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB control FSM for a multicycle MIPS-like datapath.
// Define MC_ILL_TRAP_EN to trap illegal opcodes into HALT with ill set; otherwise they run as NOPs.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       iord,
  output logic       wir,
  output logic       wpc,
  output logic       wmem,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic       sext,
  output logic [1:0] alua_sel,
  output logic [1:0] alub_sel,
  output logic [2:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       ill
);
  state_t     cur, nxt;
  logic       d_rtype, d_shift, d_iarith, d_lw, d_sw, d_br, d_j, d_ill, d_bne, d_sext;
  logic [2:0] d_aluc;
  logic       taken;
  mc_decode u_dec (
    .op(op), .func(func), .rtype(d_rtype), .shift(d_shift), .iarith(d_iarith),
    .lw(d_lw), .sw(d_sw), .br(d_br), .j(d_j), .ill(d_ill), .bne(d_bne),
    .sext(d_sext), .aluc(d_aluc)
  );
`ifdef MC_ILL_TRAP_EN
  localparam state_t ILL_NEXT = S_HALT;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) ill <= 1'b0;
    else if (cur == S_ID && d_ill) ill <= 1'b1;
`else
  localparam state_t ILL_NEXT = S_IF;
  assign ill = 1'b0;
`endif
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) cur <= S_IF;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    case (cur)
      S_IF:    nxt = mem_rdy ? S_ID : S_IF;
      S_ID:    nxt = d_j ? S_IF : d_ill ? ILL_NEXT : S_EXE;
      S_EXE:   nxt = (d_rtype | d_shift | d_iarith) ? S_WB : (d_lw | d_sw) ? S_MEM : S_IF;
      S_MEM:   nxt = !mem_rdy ? S_MEM : d_lw ? S_WB : S_IF;
      S_WB:    nxt = S_IF;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end
  assign taken = d_br & (d_bne ? ~zero : zero);
  assign state = cur;
  // HALT drives nothing, so reset reuses it to silence every strobe while clrn is low
  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    wir      = 1'b0;
    wpc      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    sext     = 1'b0;
    alua_sel = ALUA_A;
    alub_sel = ALUB_B;
    aluc     = ALU_ADD;
    pcsource = PCS_ALU;
    case (clrn ? cur : S_HALT)
      S_IF: begin
        mem_req  = 1'b1;
        alua_sel = ALUA_PC;
        alub_sel = ALUB_FOUR;
        wir      = mem_rdy;
        wpc      = mem_rdy;
      end
      S_ID: begin
        alua_sel = ALUA_PC;
        alub_sel = ALUB_IMM2;
        sext     = 1'b1;
        wpc      = d_j;
        pcsource = d_j ? PCS_JUMP : PCS_ALU;
      end
      S_EXE: begin
        alua_sel = d_shift ? ALUA_SHAMT : ALUA_A;
        alub_sel = (d_iarith | d_lw | d_sw) ? ALUB_IMM : ALUB_B;
        sext     = d_sext | d_lw | d_sw;
        aluc     = d_br ? ALU_SUB : d_aluc;
        wpc      = taken;
        pcsource = taken ? PCS_ALUOUT : PCS_ALU;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        wmem    = d_sw & mem_rdy;
      end
      S_WB: begin
        wreg  = 1'b1;
        regrt = d_iarith | d_lw;
        m2reg = d_lw;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors; the driver queues expected outputs, a negedge monitor checks them.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic       req, iord, wir, wpc, wmem, wreg, regrt, m2reg, sext;
    logic [1:0] alua, alub;
    logic [2:0] aluc;
    logic [1:0] pcs;
    logic       ill;
  } exp_t;
  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_rdy = 1'b0;
  logic       mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, sext, ill;
  logic [1:0] alua_sel, alub_sel, pcsource;
  logic [2:0] aluc, state;
  exp_t       eq[$];
  string      nq[$];
  int         checks = 0, errors = 0;
  exp_t       zr, if_w, if_r, idc, id_j;
  multicycle_ctrl dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .iord(iord), .wir(wir), .wpc(wpc), .wmem(wmem), .wreg(wreg),
    .regrt(regrt), .m2reg(m2reg), .sext(sext), .alua_sel(alua_sel), .alub_sel(alub_sel),
    .aluc(aluc), .pcsource(pcsource), .state(state), .ill(ill)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [2:0] st, input logic rq, io, ir, pc, wm, wr, rt, m2, sx,
                              input logic [1:0] aa, ab, input logic [2:0] ac, input logic [1:0] ps,
                              input logic il);
    return {st, rq, io, ir, pc, wm, wr, rt, m2, sx, aa, ab, ac, ps, il};
  endfunction
  function automatic exp_t exe(input logic [1:0] aa, ab, input logic [2:0] ac, input logic sx);
    return mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, sx, aa, ab, ac, 2'd0, 0);
  endfunction
  function automatic exp_t exb(input logic tk);
    return mk(3'd2, 0, 0, 0, tk, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd6, tk ? 2'd1 : 2'd0, 0);
  endfunction
  function automatic exp_t wb(input logic rt, m2);
    return mk(3'd4, 0, 0, 0, 0, 0, 1, rt, m2, 0, 2'd0, 2'd0, 3'd0, 2'd0, 0);
  endfunction
  function automatic exp_t mem(input logic wm);
    return mk(3'd3, 1, 1, 0, 0, wm, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 2'd0, 0);
  endfunction
  task automatic cyc(input logic c, input logic [5:0] o, f, input logic z, r, input exp_t e, input string n);
    clrn = c; op = o; func = f; zero = z; mem_rdy = r;
    eq.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input logic [5:0] o, f, input string n);
    cyc(1, 6'h3f, 6'h3f, 1, 1, if_r, {n, "_if"});
    cyc(1, o, f, 0, 1, idc, {n, "_id"});
  endtask
  always @(negedge clk) begin
    exp_t got, e;
    string n;
    if (eq.size() > 0) begin
      got = {state, mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, sext,
             alua_sel, alub_sel, aluc, pcsource, ill};
      e = eq.pop_front();
      n = nq.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, got, e);
      end
    end
  end
  initial begin
    zr   = '0;
    if_w = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, 2'd0, 0);
    if_r = mk(3'd0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, 2'd0, 0);
    idc  = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd3, 3'd0, 2'd0, 0);
    id_j = mk(3'd1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'd1, 2'd3, 3'd0, 2'd2, 0);
    #2 clrn = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 6'h00, 6'h01, 1, 1, zr, "reset0");
    cyc(0, 6'h0e, 6'h01, 1, 1, zr, "reset1");
    fetch_decode(6'h00, 6'h01, "add");
    cyc(1, 6'h00, 6'h01, 0, 1, exe(2'd0, 2'd0, 3'd0, 0), "add_exe");
    cyc(1, 6'h00, 6'h01, 0, 1, wb(0, 0), "add_wb");
    fetch_decode(6'h01, 6'h02, "or");
    cyc(1, 6'h01, 6'h02, 0, 1, exe(2'd0, 2'd0, 3'd2, 0), "or_exe");
    cyc(1, 6'h01, 6'h02, 0, 1, wb(0, 0), "or_wb");
    fetch_decode(6'h02, 6'h03, "sll");
    cyc(1, 6'h02, 6'h03, 0, 1, exe(2'd2, 2'd0, 3'd5, 0), "sll_exe");
    cyc(1, 6'h02, 6'h03, 0, 1, wb(0, 0), "sll_wb");
    fetch_decode(6'h02, 6'h01, "sra");
    cyc(1, 6'h02, 6'h01, 0, 1, exe(2'd2, 2'd0, 3'd7, 0), "sra_exe");
    cyc(1, 6'h02, 6'h01, 0, 1, wb(0, 0), "sra_wb");
    fetch_decode(6'h05, 6'h00, "addi");
    cyc(1, 6'h05, 6'h00, 0, 1, exe(2'd0, 2'd2, 3'd0, 1), "addi_exe");
    cyc(1, 6'h05, 6'h00, 0, 1, wb(1, 0), "addi_wb");
    fetch_decode(6'h0c, 6'h00, "xori");
    cyc(1, 6'h0c, 6'h00, 0, 1, exe(2'd0, 2'd2, 3'd3, 0), "xori_exe");
    cyc(1, 6'h0c, 6'h00, 0, 1, wb(1, 0), "xori_wb");
    fetch_decode(6'h09, 6'h00, "andi");
    cyc(1, 6'h09, 6'h00, 0, 1, exe(2'd0, 2'd2, 3'd1, 0), "andi_exe");
    cyc(1, 6'h09, 6'h00, 0, 1, wb(1, 0), "andi_wb");
    fetch_decode(6'h0d, 6'h00, "lw");
    cyc(1, 6'h0d, 6'h00, 0, 1, exe(2'd0, 2'd2, 3'd0, 1), "lw_exe");
    cyc(1, 6'h0d, 6'h00, 0, 0, mem(0), "lw_mem_wait0");
    cyc(1, 6'h0d, 6'h00, 0, 0, mem(0), "lw_mem_wait1");
    cyc(1, 6'h0d, 6'h00, 0, 1, mem(0), "lw_mem_done");
    cyc(1, 6'h0d, 6'h00, 0, 1, wb(1, 1), "lw_wb");
    cyc(1, 6'h0e, 6'h00, 0, 0, if_w, "sw_if_wait");
    fetch_decode(6'h0e, 6'h00, "sw");
    cyc(1, 6'h0e, 6'h00, 0, 1, exe(2'd0, 2'd2, 3'd0, 1), "sw_exe");
    cyc(1, 6'h0e, 6'h00, 0, 0, mem(0), "sw_mem_wait");
    cyc(1, 6'h0e, 6'h00, 0, 1, mem(1), "sw_mem_write");
    fetch_decode(6'h0f, 6'h00, "beq_t");
    cyc(1, 6'h0f, 6'h00, 1, 1, exb(1), "beq_t_exe");
    fetch_decode(6'h0f, 6'h00, "beq_n");
    cyc(1, 6'h0f, 6'h00, 0, 1, exb(0), "beq_n_exe");
    fetch_decode(6'h10, 6'h00, "bne_n");
    cyc(1, 6'h10, 6'h00, 1, 1, exb(0), "bne_n_exe");
    fetch_decode(6'h10, 6'h00, "bne_t");
    cyc(1, 6'h10, 6'h00, 0, 1, exb(1), "bne_t_exe");
    cyc(1, 6'h3f, 6'h00, 0, 1, if_r, "j_if");
    cyc(1, 6'h12, 6'h00, 0, 1, id_j, "j_id");
    fetch_decode(6'h0e, 6'h00, "swr");
    cyc(1, 6'h0e, 6'h00, 0, 1, exe(2'd0, 2'd2, 3'd0, 1), "swr_exe");
    cyc(1, 6'h0e, 6'h00, 0, 0, mem(0), "swr_mem_wait");
    cyc(0, 6'h0e, 6'h00, 0, 1, zr, "swr_reset");
    cyc(1, 6'h0e, 6'h00, 0, 1, if_r, "swr_restart_if");
    cyc(1, 6'h12, 6'h00, 0, 1, id_j, "swr_restart_j");
    fetch_decode(6'h3f, 6'h3f, "ill");
`ifdef MC_ILL_TRAP_EN
    cyc(1, 6'h00, 6'h01, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 2'd0, 1), "ill_halt0");
    cyc(1, 6'h0e, 6'h01, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 2'd0, 1), "ill_halt1");
    cyc(0, 6'h0e, 6'h01, 0, 1, zr, "ill_reset");
`endif
    cyc(1, 6'h00, 6'h01, 0, 1, if_r, "ill_next_if");
    cyc(1, 6'h00, 6'h01, 0, 1, idc, "ill_next_id");
    @(negedge clk);
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", eq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
